// File: rtl/ex_mem_stage_skid.sv
// EX/MEM pipeline stage with a 2-entry skid buffer, valid/ready handshake and
// synchronous flush. All outputs come straight from flops; in_ready never depends on out_ready.
module ex_mem_stage_skid #(
    parameter int unsigned                XLEN     = 32,
    parameter int unsigned                RADDR_W  = 5,
    parameter int unsigned                CTRL_W   = 6,
    parameter logic [RADDR_W-1:0]         RD_RESET = '1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_alu,
    input  logic [XLEN-1:0]     in_store,
    input  logic [RADDR_W-1:0]  in_rd,
    input  logic [CTRL_W-1:0]   in_ctrl,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_alu,
    output logic [XLEN-1:0]     out_store,
    output logic [RADDR_W-1:0]  out_rd,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [1:0]          occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic main_ld_in;
    logic main_ld_skid;
    logic skid_ld;

    logic [XLEN-1:0]    skid_pc;
    logic [XLEN-1:0]    skid_alu;
    logic [XLEN-1:0]    skid_store;
    logic [RADDR_W-1:0] skid_rd;
    logic [CTRL_W-1:0]  skid_ctrl;

    // State register plus registered handshake/occupancy decoded from next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != TWO);
            occupancy <= 2'(state_nxt);
        end
    end

    // Next-state and load selects; flush overrides everything
    always_comb begin
        state_nxt    = state;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    state_nxt  = ONE;
                    main_ld_in = 1'b1;
                end
            end
            ONE: begin
                if (in_valid && out_ready) begin
                    main_ld_in = 1'b1;
                end else if (in_valid) begin
                    state_nxt = TWO;
                    skid_ld   = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    state_nxt    = ONE;
                    main_ld_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt    = EMPTY;
            main_ld_in   = 1'b0;
            main_ld_skid = 1'b0;
            skid_ld      = 1'b0;
        end
    end

    // Main (output) register; ctrl is cleared whenever the stage goes empty so bubbles are inert
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_pc    <= '0;
            out_alu   <= '0;
            out_store <= '0;
            out_rd    <= RD_RESET;
            out_ctrl  <= '0;
        end else begin
            if (main_ld_in) begin
                out_pc    <= in_pc;
                out_alu   <= in_alu;
                out_store <= in_store;
                out_rd    <= in_rd;
                out_ctrl  <= in_ctrl;
            end else if (main_ld_skid) begin
                out_pc    <= skid_pc;
                out_alu   <= skid_alu;
                out_store <= skid_store;
                out_rd    <= skid_rd;
                out_ctrl  <= skid_ctrl;
            end
            if (flush) begin
                out_rd   <= RD_RESET;
                out_ctrl <= '0;
            end else if (state_nxt == EMPTY) begin
                out_ctrl <= '0;
            end
        end
    end

    // Skid register holds the second entry while MEM stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_pc    <= '0;
            skid_alu   <= '0;
            skid_store <= '0;
            skid_rd    <= RD_RESET;
            skid_ctrl  <= '0;
        end else if (flush) begin
            skid_rd    <= RD_RESET;
            skid_ctrl  <= '0;
        end else if (skid_ld) begin
            skid_pc    <= in_pc;
            skid_alu   <= in_alu;
            skid_store <= in_store;
            skid_rd    <= in_rd;
            skid_ctrl  <= in_ctrl;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_skid.sv
// Randomised and directed bench for ex_mem_stage_skid against a queue-based FIFO model.
module tb_ex_mem_stage_skid;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_alu, in_store;
    logic [4:0]  in_rd;
    logic [5:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_alu, out_store;
    logic [4:0]  out_rd;
    logic [5:0]  out_ctrl;
    logic [1:0]  occupancy;

    ex_mem_stage_skid dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_alu    (in_alu),
        .in_store  (in_store),
        .in_rd     (in_rd),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_alu   (out_alu),
        .out_store (out_store),
        .out_rd    (out_rd),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  rd;
        logic [5:0]  ctrl;
    } bundle_t;

    bundle_t q[$];
    bit      rd_known;
    int      n_checks;
    int      n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_alu   = $urandom;
        in_store = $urandom;
        in_rd    = 5'($urandom);
        in_ctrl  = 6'($urandom);
    endtask

    task automatic check_reset_vals();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_occ",       64'(occupancy), 64'd0);
        check("rst_pc",        64'(out_pc),    64'd0);
        check("rst_alu",       64'(out_alu),   64'd0);
        check("rst_store",     64'(out_store), 64'd0);
        check("rst_rd",        64'(out_rd),    64'd31);
        check("rst_ctrl",      64'(out_ctrl),  64'd0);
    endtask

    task automatic compare_all();
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("in_ready",  64'(in_ready),  64'(q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_pc",    64'(out_pc),    64'(q[0].pc));
            check("out_alu",   64'(out_alu),   64'(q[0].alu));
            check("out_store", 64'(out_store), 64'(q[0].st));
            check("out_rd",    64'(out_rd),    64'(q[0].rd));
            check("out_ctrl",  64'(out_ctrl),  64'(q[0].ctrl));
        end else begin
            check("bubble_ctrl", 64'(out_ctrl), 64'd0);
            if (rd_known) check("idle_rd", 64'(out_rd), 64'd31);
        end
    endtask

    // One clock: model update from the rules of the handshake, then compare
    task automatic step();
        bundle_t b;
        bit in_fire, out_fire;
        in_fire  = in_valid && (q.size() < 2);
        out_fire = out_ready && (q.size() > 0);
        b.pc = in_pc; b.alu = in_alu; b.st = in_store; b.rd = in_rd; b.ctrl = in_ctrl;
        @(posedge clk);
        if (out_fire) void'(q.pop_front());
        if (flush) begin
            q.delete();
            rd_known = 1'b1;
        end else if (in_fire) begin
            q.push_back(b);
            rd_known = 1'b0;
        end
        #1;
        compare_all();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        reset    = 1'b1;
        rd_known = 1'b1;

        // back-to-back stream with MEM always ready
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(i * 4));
            step();
        end
        set_in(1'b0, 32'h0);
        step();

        // MEM stall fills the skid, then drains in order
        out_ready = 1'b0;
        set_in(1'b1, 32'h10); step();
        set_in(1'b1, 32'h14); step();
        check("stall_hold_pc", 64'(out_pc), 64'h10);
        set_in(1'b1, 32'h18); step();
        out_ready = 1'b1;
        set_in(1'b0, 32'h0);  step();
        check("drain_second_pc", 64'(out_pc), 64'h14);
        step();

        // flush while full
        out_ready = 1'b0;
        set_in(1'b1, 32'h30); step();
        set_in(1'b1, 32'h34); step();
        set_in(1'b0, 32'h0);
        flush = 1'b1; step();
        flush = 1'b0;
        check("flush_rd", 64'(out_rd), 64'd31);

        // flush together with a new input while one entry is transferring
        out_ready = 1'b1;
        set_in(1'b1, 32'h1C); step();
        set_in(1'b1, 32'h20);
        flush = 1'b1; step();
        flush = 1'b0;
        set_in(1'b0, 32'h0);
        step();
        check("no_0x20_valid", 64'(out_valid), 64'd0);

        // asynchronous reset in the middle of a cycle while full
        out_ready = 1'b0;
        set_in(1'b1, 32'h50); step();
        set_in(1'b1, 32'h54); step();
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals();
        q.delete();
        rd_known = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'h40); step();
        check("post_reset_pc", 64'(out_pc), 64'h40);
        set_in(1'b0, 32'h0); step();

        // bubbles with all control bits set on the input
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 32'($urandom));
            in_ctrl   = 6'b111111;
            out_ready = 1'($urandom);
            step();
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
